uart_bus_slave: RTL and testbench

UART_BUS_SLAVE -- requirements
Module: uart_bus_slave

---
 rtl/uart_bus_slave.sv | 204 ++++++++++++++++++++
 tb/tb_uart_bus_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_slave.sv
// Memory-mapped UART: DATA/STATUS registers on the CPU data bus, 4-entry TX FIFO,
// 8N1 transmitter and receiver sharing a single clock-derived baud divisor.
module uart_bus_slave #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_ce_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_i,
    input  logic [3:0]  bus_sel_i,
    input  logic [31:0] bus_data_i,
    output logic [31:0] bus_data_o,
    output logic        txd,
    input  logic        rxd
);

    localparam int unsigned DIV     = CLK_FREQ / BAUD;
    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'((DIV >= 2) ? (DIV / 2 - 1) : 0);

    localparam logic [31:0] ADDR_DATA   = 32'hBFD0_03F8;
    localparam logic [31:0] ADDR_STATUS = 32'hBFD0_03FC;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          sel_data, sel_status, data_read;
    logic          push_req, push_ok, tx_pop, tx_not_full;
    logic [7:0]    fifo_mem [4];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    fifo_count;

    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    logic          rx_s1, rx_s2;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          rx_valid;

    logic          unused_bits;
    assign unused_bits = ^{bus_sel_i[3:1], bus_data_i[31:8]};

    assign sel_data    = bus_ce_i && (bus_addr_i == ADDR_DATA);
    assign sel_status  = bus_ce_i && (bus_addr_i == ADDR_STATUS);
    assign data_read   = sel_data && !bus_we_i;
    assign tx_not_full = (fifo_count != 3'd4);
    assign tx_pop      = (tx_state == S_IDLE) && (fifo_count != 3'd0);
    assign push_req    = sel_data && bus_we_i && bus_sel_i[0];
    // A full FIFO still accepts a push when the transmitter pops in the same cycle.
    assign push_ok     = push_req && (tx_not_full || tx_pop);

    always_comb begin
        bus_data_o = '0;
        if (bus_ce_i && !bus_we_i) begin
            if (sel_data)
                bus_data_o = {24'b0, rx_byte};
            else if (sel_status)
                bus_data_o = {30'b0, rx_valid, tx_not_full};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            fifo_mem[wr_ptr] <= bus_data_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 2'd1;
            if (tx_pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, tx_pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else begin
            // txd is registered from the current state, so the line lags the FSM by one cycle.
            case (tx_state)
                S_START: txd <= 1'b0;
                S_DATA:  txd <= tx_shift[tx_bit];
                default: txd <= 1'b1;
            endcase
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_state <= S_START;
                        tx_cnt   <= DIV_M1;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= S_DATA;
                        tx_cnt   <= DIV_M1;
                        tx_bit   <= '0;
                    end else
                        tx_cnt <= tx_cnt - CW'(1);
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= DIV_M1;
                        if (tx_bit == 3'd7)
                            tx_state <= S_STOP;
                        else
                            tx_bit <= tx_bit + 3'd1;
                    end else
                        tx_cnt <= tx_cnt - CW'(1);
                end
                default: begin
                    if (tx_cnt == '0) begin
                        tx_state <= S_IDLE;
                        tx_cnt   <= DIV_M1;
                    end else
                        tx_cnt <= tx_cnt - CW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            // A completing byte below overrides this clear when both land on one edge.
            if (data_read)
                rx_valid <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s2) begin
                        rx_state <= S_START;
                        rx_cnt   <= HALF_M1;
                    end
                end
                S_START: begin
                    if (rx_cnt == '0) begin
                        rx_cnt   <= DIV_M1;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else
                        rx_cnt <= rx_cnt - CW'(1);
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= DIV_M1;
                        if (rx_bit == 3'd7)
                            rx_state <= S_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else
                        rx_cnt <= rx_cnt - CW'(1);
                end
                default: begin
                    if (rx_cnt == '0) begin
                        if (rx_s2) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                        rx_state <= S_IDLE;
                        rx_cnt   <= DIV_M1;
                    end else
                        rx_cnt <= rx_cnt - CW'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_slave.sv
// Self-checking bench for uart_bus_slave at DIV=16: directed register/frame cases
// plus randomized bus and serial traffic against a frame-timing reference model.
module tb_uart_bus_slave;

    localparam int DIV = 16;
    localparam logic [31:0] ADDR_DATA   = 32'hBFD0_03F8;
    localparam logic [31:0] ADDR_STATUS = 32'hBFD0_03FC;

    logic        clk;
    logic        rst;
    logic        bus_ce_i, bus_we_i;
    logic [31:0] bus_addr_i;
    logic [3:0]  bus_sel_i;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        txd;
    logic        rxd;

    uart_bus_slave #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_ce_i   (bus_ce_i),
        .bus_we_i   (bus_we_i),
        .bus_addr_i (bus_addr_i),
        .bus_sel_i  (bus_sel_i),
        .bus_data_i (bus_data_i),
        .bus_data_o (bus_data_o),
        .txd        (txd),
        .rxd        (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, transmitter as "frame started at edge P".
    logic [7:0] m_q[$];
    int         m_edge      = 0;
    bit         m_started   = 0;
    bit         m_have_fr   = 0;
    int         m_pop_edge  = 0;
    int         m_free_at   = 0;
    logic [7:0] m_cur       = '0;
    logic       m_rx_valid  = 1'b0;
    logic [7:0] m_rx_byte   = '0;
    int         m_sz;
    bit         m_pop;

    function automatic logic exp_txd();
        int k;
        int idx;
        if (!m_have_fr) return 1'b1;
        k = m_edge - m_pop_edge - 1;
        if (k < 0 || k >= 10 * DIV) return 1'b1;
        idx = k / DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    always begin
        @(posedge clk);
        m_edge++;
        if (rst) begin
            m_q.delete();
            m_have_fr  = 0;
            m_free_at  = m_edge + 1;
            m_rx_valid = 1'b0;
            m_rx_byte  = '0;
            m_started  = 1;
        end else begin
            m_sz  = m_q.size();
            m_pop = (m_edge >= m_free_at) && (m_sz > 0);
            if (m_pop) begin
                m_cur      = m_q.pop_front();
                m_pop_edge = m_edge;
                m_have_fr  = 1;
                m_free_at  = m_edge + 10 * DIV + 1;
            end
            if (bus_ce_i && bus_we_i && bus_addr_i == ADDR_DATA && bus_sel_i[0] && (m_sz < 4 || m_pop))
                m_q.push_back(bus_data_i[7:0]);
            if (bus_ce_i && !bus_we_i && bus_addr_i == ADDR_DATA)
                m_rx_valid = 1'b0;
        end
        #1;
        if (m_started)
            check("txd", 32'(txd), 32'(exp_txd()));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
        bus_ce_i   = 1'b1;
        bus_we_i   = 1'b1;
        bus_addr_i = addr;
        bus_sel_i  = sel;
        bus_data_i = data;
        #1;
        check("rdata_during_write", bus_data_o, 32'h0);
        @(negedge clk);
        bus_ce_i = 1'b0;
        bus_we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input string tag, output logic [31:0] val);
        logic [31:0] exp;
        bus_ce_i   = 1'b1;
        bus_we_i   = 1'b0;
        bus_addr_i = addr;
        bus_sel_i  = 4'($urandom);
        #1;
        if (addr == ADDR_DATA)
            exp = {24'b0, m_rx_byte};
        else if (addr == ADDR_STATUS)
            exp = {30'b0, m_rx_valid, (m_q.size() != 4)};
        else
            exp = '0;
        val = bus_data_o;
        check(tag, val, exp);
        @(negedge clk);
        bus_ce_i = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        if (stop_ok) begin
            m_rx_byte  = b;
            m_rx_valid = 1'b1;
        end
        // A low stop bit retriggers a start search that must time out before the next frame.
        repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic rx_glitch(input int len);
        rxd = 1'b0;
        repeat (len) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

    logic [31:0] v;
    logic [9:0]  frame;

    initial begin
        rst        = 1'b1;
        bus_ce_i   = 1'b0;
        bus_we_i   = 1'b0;
        bus_addr_i = '0;
        bus_sel_i  = '0;
        bus_data_i = '0;
        rxd        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("txd_reset", 32'(txd), 32'h1);
        bus_read(ADDR_STATUS, "status_reset", v);
        check("status_reset_const", v, 32'h1);
        bus_read(32'hBFD0_0000, "unmapped_read", v);
        bus_write(ADDR_STATUS, 4'hF, 32'h0000_00FF);
        bus_write(ADDR_DATA, 4'b1110, 32'h0000_0077);
        bus_read(ADDR_STATUS, "status_after_ignored", v);
        check("status_after_ignored_const", v, 32'h1);
        idle(12 * DIV);

        // Single 0x5A frame with exact start latency and per-bit mid-point samples
        bus_write(ADDR_DATA, 4'h1, 32'h0000_005A);
        idle(1);
        check("tx_prestart_high", 32'(txd), 32'h1);
        idle(1);
        check("tx_start_low", 32'(txd), 32'h0);
        idle(8);
        frame = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 10; i++) begin
            check("tx_5a_bit", 32'(txd), 32'(frame[i]));
            idle(DIV);
        end
        idle(2 * DIV);

        // FIFO overflow: six back-to-back writes, sixth dropped
        for (int i = 1; i <= 6; i++)
            bus_write(ADDR_DATA, 4'h1, 32'(i));
        bus_read(ADDR_STATUS, "status_fifo_full", v);
        check("status_full_bit0", 32'(v[0]), 32'h0);
        idle(6 * 10 * DIV + 20);

        // RX 0xC3
        rx_frame(8'hC3, 1'b1);
        bus_read(ADDR_STATUS, "status_rx_valid", v);
        check("status_rx_valid_const", v, 32'h3);
        bus_read(ADDR_DATA, "data_rx", v);
        check("data_rx_const", v, 32'h0000_00C3);
        bus_read(ADDR_STATUS, "status_rx_cleared", v);
        check("status_rx_cleared_const", v, 32'h1);

        // Glitch and framing error both leave nothing behind
        rx_glitch(4);
        bus_read(ADDR_STATUS, "status_after_glitch", v);
        check("status_after_glitch_const", v, 32'h1);
        rx_frame(8'h96, 1'b0);
        bus_read(ADDR_STATUS, "status_after_frame_err", v);
        check("status_after_frame_err_const", v, 32'h1);
        bus_read(ADDR_DATA, "data_after_frame_err", v);

        // Reset in the middle of a transmitted DATA bit
        bus_write(ADDR_DATA, 4'h1, 32'h0000_00A5);
        bus_write(ADDR_DATA, 4'h1, 32'h0000_003C);
        idle(40);
        rst = 1'b1;
        bus_read(ADDR_STATUS, "status_decode_in_rst", v);
        check("txd_after_rst", 32'(txd), 32'h1);
        bus_write(ADDR_DATA, 4'h1, 32'h0000_00FF);
        rst = 1'b0;
        bus_read(ADDR_STATUS, "status_after_rst", v);
        check("status_after_rst_const", v, 32'h1);
        idle(12 * DIV);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3:
                    bus_write(($urandom_range(0, 5) == 0) ? ADDR_STATUS : ADDR_DATA,
                              4'($urandom), $urandom);
                4: bus_read(ADDR_STATUS, "rnd_status", v);
                5: bus_read(ADDR_DATA, "rnd_data", v);
                6: bus_read(32'h1000_0000 + 32'($urandom_range(0, 255)), "rnd_unmapped", v);
                7: rx_frame(8'($urandom), ($urandom_range(0, 7) != 0));
                8: rx_glitch($urandom_range(1, 6));
                default: idle($urandom_range(1, 200));
            endcase
        end
        idle(5 * 10 * DIV + 50);
        bus_read(ADDR_STATUS, "final_status", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
